// File: rtl/i2c_rx_ctrl.sv
// i2c_rx_ctrl: receive-side I2C slave controller; gates the shift register, checks the address,
// drives ACK/NACK and pushes received data bytes into the receive FIFO.
module i2c_rx_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic [7:0] rx_data,
    input  logic       fifo_full,
    output logic       rx_enable,
    output logic       sda_ack_en,
    output logic       fifo_w_en,
    output logic [7:0] fifo_w_data,
    output logic       address_match,
    output logic       read_mode,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_CHK, ACK_ADDR, DATA, DATA_CHK, ACK_DATA, NACK, IGNORE, READ_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       ack_q, ack_d, wen_q, wen_d, am_q, am_d, rm_q, rm_d, ovr_q, ovr_d;
    logic [7:0] wdata_q, wdata_d;

    assign rx_enable     = (state_q == ADDR || state_q == DATA) && bit_cnt_q < 4'd8;
    assign busy          = state_q != IDLE;
    assign sda_ack_en    = ack_q;
    assign fifo_w_en     = wen_q;
    assign fifo_w_data   = wdata_q;
    assign address_match = am_q;
    assign read_mode     = rm_q;
    assign overrun       = ovr_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = (rx_enable && rising_edge_found) ? bit_cnt_q + 4'd1 : bit_cnt_q;
        am_d      = am_q;
        rm_d      = rm_q;
        wen_d     = 1'b0;
        wdata_d   = wdata_q;
        ovr_d     = 1'b0;
        case (state_q)
            ADDR:     if (falling_edge_found && bit_cnt_q == 4'd8) state_d = ADDR_CHK;
            ADDR_CHK: begin
                if (rx_data[7:1] == SLAVE_ADDR) begin
                    am_d    = 1'b1;
                    rm_d    = rx_data[0];
                    state_d = ACK_ADDR;
                end else begin
                    state_d = IGNORE;
                end
            end
            ACK_ADDR: begin
                if (falling_edge_found) begin
                    state_d   = rm_q ? READ_HOLD : DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            DATA:     if (falling_edge_found && bit_cnt_q == 4'd8) state_d = DATA_CHK;
            DATA_CHK: begin
                if (!fifo_full) begin
                    wen_d   = 1'b1;
                    wdata_d = rx_data;
                    state_d = ACK_DATA;
                end else begin
                    ovr_d   = 1'b1;
                    state_d = NACK;
                end
            end
            ACK_DATA: begin
                if (falling_edge_found) begin
                    state_d   = DATA;
                    bit_cnt_d = 4'd0;
                end
            end
            NACK:     if (falling_edge_found) state_d = IGNORE;
            default:  state_d = state_q;
        endcase
        // bus conditions override everything; a START also restarts the address phase
        if (start_found || stop_found) begin
            state_d   = start_found ? ADDR : IDLE;
            bit_cnt_d = 4'd0;
            am_d      = 1'b0;
            rm_d      = 1'b0;
            wen_d     = 1'b0;
            wdata_d   = wdata_q;
            ovr_d     = 1'b0;
        end
        ack_d = state_d == ACK_ADDR || state_d == ACK_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            ack_q     <= 1'b0;
            wen_q     <= 1'b0;
            wdata_q   <= 8'h00;
            am_q      <= 1'b0;
            rm_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ack_q     <= ack_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            am_q      <= am_d;
            rm_q      <= rm_d;
            ovr_q     <= ovr_d;
        end
    end
endmodule
